instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Requester side of the stage-1 instruction memory port.
- Generates the fetch PC and drives the memory's byte address and stall inputs.
- Tracks the memory's fixed 2-cycle read pipeline so each returned instruction carries its PC and a valid flag.
- Handles downstream stalls without losing an in-flight fetch, and squashes wrong-path fetches on redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched in the first cycle after reset release. Low 2 bits must be 0.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  downstream hold request. Passed through to the memory stall port.
- redirect  in  1  branch/jump taken. Flushes all in-flight fetches.
- redirect_target  in  32  new PC. Bits [1:0] are forced to 0 internally.
- instruction_addr  out  32  byte address to the memory's long_instruction_addr.
- memory_stall  out  1  equals stall (combinational).
- memory_instruction  in  32  instruction word returned by memory.
- instruction  out  32  equals memory_instruction (combinational).
- instruction_pc  out  32  PC of the word currently on instruction.
- instruction_valid  out  1  instruction/instruction_pc hold a live, non-squashed fetch.

Behaviour:
- Memory timing contract:
  - Address presented in cycle N is latched unconditionally at the end of N.
  - Its data is written to the memory output register at the end of N+1, but only if stall=0 in N+1.
  - The output register holds its value while stall=1.
- Registers:
  - fetch_pc
  - pc_d1, valid_d1: mirror the memory's address-delay stage.
  - instruction_pc, instruction_valid: mirror the memory's output stage.
- Reset (async, reset_n=0):
  - fetch_pc=RESET_PC, pc_d1=RESET_PC, instruction_pc=RESET_PC.
  - valid_d1=0, instruction_valid=0.
- Address mux (combinational): instruction_addr = stall ? pc_d1 : fetch_pc.
  - Re-presenting pc_d1 during a stall keeps the address in the memory's delay stage alive.
  - Without this, that address would be overwritten and lost.
- fetch_pc update:
  - redirect=1: fetch_pc <= {redirect_target[31:2],2'b00}. Redirect has priority over stall.
  - else stall=1: hold.
  - else: fetch_pc <= fetch_pc+4. Wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Delay stage, every cycle: pc_d1 <= instruction_addr.
- valid_d1 next value:
  - redirect=1: 0.
  - else stall=1: hold.
  - else: 1.
- Output stage:
  - stall=0: instruction_pc <= pc_d1; instruction_valid <= valid_d1 & !redirect.
  - stall=1: hold instruction_pc; instruction_valid <= instruction_valid & !redirect.
- Latency and throughput:
  - Instruction at address A, issued in cycle N with no stalls, appears with valid=1 in cycle N+2.
  - Steady state: one instruction per cycle.
- First valid output is in the 2nd cycle after reset release, with instruction_pc=RESET_PC.
- Redirect in cycle t:
  - The t and t-1 fetches are squashed.
  - instruction_valid=0 in t+1 and t+2.
  - Target appears valid in t+3 if no stall.
- Redirect under stall:
  - Held output is invalidated at the next edge.
  - Target fetch issues the cycle after stall drops.
- Back-to-back redirects: the last one wins; no stale fetch is ever marked valid.
- No instruction is duplicated or skipped across any stall length, including stall asserted on consecutive or isolated cycles.
- Reset asserted mid-stream: all valids clear immediately (asynchronous); fetch restarts at RESET_PC.

Test Plan:
- Reset, RESET_PC=0, no stall, 6 cycles → instruction_valid 0,0,1,1,1,1; instruction_pc 0,4,8,C in cycles 2–5.
- 1-cycle stall in cycle 4, then 3-cycle stall in cycle 7 → instruction_pc sequence 0,4,8,8,C,10,10,10,10,14. Each held output keeps the same word; nothing is skipped.
- redirect=1, redirect_target=32'h0000_0103 in cycle 5 → valid=0 in cycles 6–7; valid=1 with instruction_pc=32'h100 in cycle 8, then 104.
- redirect during stall (cycle 5, stall 5–7) → instruction_valid=0 from cycle 6; target valid 2 cycles after stall releases (cycle 10).
- fetch_pc=32'hFFFF_FFF8 → instruction_pc FFFF_FFF8, FFFF_FFFC, 0000_0000 on consecutive cycles.
- reset_n pulsed low mid-cycle while valid=1 → instruction_valid falls without a clock edge; after release, restart matches scenario 1.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Purpose : stage-1 instruction fetch requester; drives the fetch address into a fixed
//           2-cycle memory and tags each returned word with its PC and a valid flag.
// Latency : a word fetched in cycle N appears on instruction/instruction_pc in cycle N+2.
// Backpressure: stall freezes fetch_pc and the output stage; the delayed address is
//           re-presented so the fetch inside the memory is not lost.
// Ports   : clock, reset_n (async, active-low); stall, redirect, redirect_target from the
//           pipeline; instruction_addr / memory_stall to the memory; memory_instruction
//           from the memory; instruction, instruction_pc, instruction_valid downstream.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic [31:0] instruction_addr,
   output logic        memory_stall,
   input  logic [31:0] memory_instruction,
   output logic [31:0] instruction,
   output logic [31:0] instruction_pc,
   output logic        instruction_valid
);

   localparam logic [31:0] START_PC = RESET_PC & ~32'd3;

   logic [31:0] fetch_pc;
   logic [31:0] pc_d1;     // address sitting in the memory's delay stage
   logic        valid_d1;  // that address belongs to a live (non-squashed) fetch

   // While stalled the memory still latches a new address every cycle, so feed it
   // back the one already in its delay stage to keep that fetch alive.
   always_comb begin
      instruction_addr = stall ? pc_d1 : fetch_pc;
   end

   assign memory_stall = stall;
   assign instruction  = memory_instruction;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc          <= START_PC;
         pc_d1             <= START_PC;
         valid_d1          <= 1'b0;
         instruction_pc    <= START_PC;
         instruction_valid <= 1'b0;
      end else begin
         // The memory latches the address unconditionally, so the mirror does too.
         pc_d1 <= instruction_addr;

         // Redirect beats stall: the target is captured now and issued once stall drops.
         if (redirect) begin
            fetch_pc <= redirect_target & ~32'd3;
            valid_d1 <= 1'b0;
         end else if (!stall) begin
            fetch_pc <= fetch_pc + 32'd4;
            valid_d1 <= 1'b1;
         end

         // Output stage follows the memory's output register, which only loads when
         // not stalled; a redirect kills whatever is there or about to arrive.
         if (!stall) begin
            instruction_pc    <= pc_d1;
            instruction_valid <= valid_d1 & ~redirect;
         end else begin
            instruction_valid <= instruction_valid & ~redirect;
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench: a behavioural 2-cycle memory answers the fetch addresses, expected PCs are
// queued per scenario and popped whenever a valid word is accepted (valid and not stalled).
module tb_instruction_fetch_unit;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_target = 32'h0;
   logic [31:0] instruction_addr;
   logic        memory_stall;
   logic [31:0] memory_instruction;
   logic [31:0] instruction;
   logic [31:0] instruction_pc;
   logic        instruction_valid;

   int tests = 0;
   int fails = 0;

   logic [31:0] exp_q[$];
   logic [31:0] tgts[$];

   instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clock              (clock),
      .reset_n            (reset_n),
      .stall              (stall),
      .redirect           (redirect),
      .redirect_target    (redirect_target),
      .instruction_addr   (instruction_addr),
      .memory_stall       (memory_stall),
      .memory_instruction (memory_instruction),
      .instruction        (instruction),
      .instruction_pc     (instruction_pc),
      .instruction_valid  (instruction_valid)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
   endfunction

   // Behavioural memory: address latched every edge, output register loads when not stalled.
   logic [31:0] mem_addr_q = 32'h0;
   logic [31:0] mem_out = 32'h0;
   always @(posedge clock) begin
      if (!memory_stall) mem_out <= mem_word(mem_addr_q);
      mem_addr_q <= instruction_addr;
   end
   assign memory_instruction = mem_out;

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Scoreboard: consume one word per accepting cycle.
   always @(negedge clock) begin
      if (reset_n) begin
         check32("memory_stall", {31'd0, memory_stall}, {31'd0, stall});
         if (instruction_valid && !stall) begin
            logic [31:0] e;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            check32("sb pc", instruction_pc, e);
            check32("sb data", instruction, mem_word(e));
         end
      end
   end

   task automatic do_reset();
      reset_n = 1'b0;
      stall = 1'b0;
      redirect = 1'b0;
      redirect_target = 32'h0;
      exp_q.delete();
      tgts.delete();
      #1;
      check32("rst valid", {31'd0, instruction_valid}, 32'd0);
      check32("rst pc", instruction_pc, 32'h0);
      check32("rst addr", instruction_addr, 32'h0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;   // this interval is cycle 0
   endtask

   task automatic run(input string tag, input int n, input logic [31:0] st,
                      input logic [31:0] rd, input logic [31:0] ev);
      for (int k = 0; k < n; k++) begin
         stall = st[k];
         redirect = rd[k];
         if (rd[k]) redirect_target = (tgts.size() != 0) ? tgts.pop_front() : 32'h0;
         else redirect_target = 32'hDEAD_BEE1;
         check32($sformatf("%s valid c%0d", tag, k), {31'd0, instruction_valid}, {31'd0, ev[k]});
         @(posedge clock);
         #1;
      end
      stall = 1'b0;
      redirect = 1'b0;
      check32({tag, " drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      // Plain stream from reset.
      do_reset();
      exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
      run("stream", 6, 32'h0, 32'h0, 32'h3C);

      // Isolated 1-cycle stall in c4, 3-cycle stall c7..c9.
      do_reset();
      exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
      run("stall", 12, 32'h390, 32'h0, 32'hFFC);

      // Redirect in c5, unaligned target.
      do_reset();
      tgts = '{32'h0000_0103};
      exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h104};
      run("redir", 10, 32'h0, 32'h20, 32'h33C);

      // Redirect in c5 under stall c5..c7: held word C is dropped.
      do_reset();
      tgts = '{32'h0000_0200};
      exp_q = '{32'h0, 32'h4, 32'h8, 32'h200, 32'h204};
      run("redir_stall", 12, 32'hE0, 32'h20, 32'hC3C);

      // Wrap past the top of the address space.
      do_reset();
      tgts = '{32'hFFFF_FFF8};
      exp_q = '{32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
      run("wrap", 9, 32'h0, 32'h4, 32'h1E4);

      // Back-to-back redirects: the second one wins.
      do_reset();
      tgts = '{32'h0000_0300, 32'h0000_0400};
      exp_q = '{32'h0, 32'h4, 32'h400, 32'h404, 32'h408};
      run("b2b", 10, 32'h0, 32'h18, 32'h38C);

      // Reset pulled mid-cycle while a word is valid, then a clean restart.
      do_reset();
      exp_q = '{32'h0, 32'h4, 32'h8};
      run("pre_rst", 5, 32'h0, 32'h0, 32'h1C);
      check32("pre_rst valid", {31'd0, instruction_valid}, 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check32("async valid", {31'd0, instruction_valid}, 32'd0);
      check32("async pc", instruction_pc, 32'h0);
      do_reset();
      exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
      run("restart", 6, 32'h0, 32'h0, 32'h3C);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
